// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// button bit positions within the {C,U,D,L,R} vector.
package btn_defs;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_WT = 2'd1,
    HELD     = 2'd2,
    REL_WT   = 2'd3
  } btn_state_t;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_C = 4;
  localparam int BTN_COUNT = 5;

endpackage

// File: rtl/btn_debounce_1.sv
// One button: 2-FF synchroniser, counter debounce FSM, level/press/release outputs.
// With BTN_AUTOREPEAT_EN defined, a held button also emits periodic repeat presses.
module btn_debounce_1
  import btn_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic s1;
  logic s;
  btn_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic level_next, press_next, rel_next;

`ifdef BTN_AUTOREPEAT_EN
  // rc reloads to DELAY-RATE after each repeat so later pulses are RATE apart;
  // this assumes REPEAT_RATE <= REPEAT_DELAY.
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RC_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RC_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);
  logic [RW-1:0] rc, rc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rc <= '0;
    else       rc <= rc_next;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= raw;
      s     <= s1;
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      press <= press_next;
      rel   <= rel_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    press_next = 1'b0;
    rel_next   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rc_next    = rc;
`endif
    case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WT;
          cnt_next   = CW'(1);
        end
      end
      PRESS_WT: begin
        if (!s) begin
          state_next = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_next = HELD;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_next = REL_WT;
          cnt_next   = CW'(1);
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rc == RC_LAST) begin
          press_next = 1'b1;
          rc_next    = RC_RELOAD;
        end else begin
          rc_next = rc + 1'b1;
        end
`endif
      end
      REL_WT: begin
        // rc is left untouched here so a bounce back to HELD resumes the count
        if (s) begin
          state_next = HELD;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE;
          level_next = 1'b0;
          rel_next   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rc_next    = '0;
`endif
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five board push-buttons: one independent debouncer per bit.
// Optional auto-repeat of held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_defs::*;
#(
  parameter int N_BTN           = BTN_COUNT,
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce_1 #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
`endif
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_raw[gi]),
        .level(btn_level[gi]),
        .press(btn_press[gi]),
        .rel  (btn_release[gi])
      );
    end
  endgenerate

endmodule
